// File: rtl/ctrseq_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and
// default sizes of the step table.
package ctrseq_pkg;

    localparam int MODE_W_DEF    = 4;
    localparam int DUR_W_DEF     = 8;
    localparam int NUM_STEPS_DEF = 4;
    localparam int STEP_W        = $clog2(NUM_STEPS_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// Host/counter-facing signal bundle of the counter sequencer.
// Optional CTRSEQ_LOOP_EN adds the Loop request bit.
interface counter_sequencer_if #(
    parameter int MODE_W    = ctrseq_pkg::MODE_W_DEF,
    parameter int DUR_W     = ctrseq_pkg::DUR_W_DEF,
    parameter int NUM_STEPS = ctrseq_pkg::NUM_STEPS_DEF
) ();
    localparam int SW = $clog2(NUM_STEPS);

    logic              Start;
    logic              Abort;
    logic              Cfg_We;
    logic [SW-1:0]     Cfg_Addr;
    logic [MODE_W-1:0] Cfg_Mode;
    logic [DUR_W-1:0]  Cfg_Dur;
    logic [SW:0]       Cfg_Num;
`ifdef CTRSEQ_LOOP_EN
    logic              Loop;
`endif
    logic [MODE_W-1:0] Ctr_Mode;
    logic              Ctr_Enable;
    logic              Ctr_nClear;
    logic              Busy;
    logic              Done;
    logic [SW-1:0]     Step;

    // Host side: issues commands/config, observes status and counter controls.
    modport master (
`ifdef CTRSEQ_LOOP_EN
        output Loop,
`endif
        output Start, Abort, Cfg_We, Cfg_Addr, Cfg_Mode, Cfg_Dur, Cfg_Num,
        input  Ctr_Mode, Ctr_Enable, Ctr_nClear, Busy, Done, Step
    );

    // Sequencer side.
    modport slave (
`ifdef CTRSEQ_LOOP_EN
        input  Loop,
`endif
        input  Start, Abort, Cfg_We, Cfg_Addr, Cfg_Mode, Cfg_Dur, Cfg_Num,
        output Ctr_Mode, Ctr_Enable, Ctr_nClear, Busy, Done, Step
    );

endinterface

// File: rtl/ctrseq_step_table.sv
// Step table: NUM_STEPS entries of (mode, duration). Synchronous write and
// clear, asynchronous read so the sequencer sees the current entry in LOAD.
module ctrseq_step_table #(
    parameter int MODE_W    = 4,
    parameter int DUR_W     = 8,
    parameter int NUM_STEPS = 4
) (
    input  logic                         Clk,
    input  logic                         nReset,
    input  logic                         i_we,
    input  logic [$clog2(NUM_STEPS)-1:0] i_waddr,
    input  logic [MODE_W-1:0]            i_mode,
    input  logic [DUR_W-1:0]             i_dur,
    input  logic [$clog2(NUM_STEPS)-1:0] i_raddr,
    output logic [MODE_W-1:0]            o_mode,
    output logic [DUR_W-1:0]             o_dur
);
    localparam int SW = $clog2(NUM_STEPS);

    logic [MODE_W-1:0] w_mode_arr [NUM_STEPS];
    logic [DUR_W-1:0]  w_dur_arr  [NUM_STEPS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STEPS; gi++) begin : g_entry
            logic [MODE_W-1:0] r_mode;
            logic [DUR_W-1:0]  r_dur;

            // Entry storage: cleared by reset, loaded when addressed by a write.
            always_ff @(posedge Clk) begin
                if (!nReset) begin
                    r_mode <= '0;
                    r_dur  <= '0;
                end else if (i_we && (i_waddr == SW'(gi))) begin
                    r_mode <= i_mode;
                    r_dur  <= i_dur;
                end
            end

            assign w_mode_arr[gi] = r_mode;
            assign w_dur_arr[gi]  = r_dur;
        end
    endgenerate

    assign o_mode = w_mode_arr[i_raddr];
    assign o_dur  = w_dur_arr[i_raddr];

endmodule

// File: rtl/counter_sequencer.sv
// Counter sequencer: walks the step table, clearing the counter, applying
// each step's mode and enabling it for the programmed number of cycles.
// Optional feature macro: CTRSEQ_LOOP_EN (repeat the sequence until Abort).
module counter_sequencer
    import ctrseq_pkg::*;
#(
    parameter int MODE_W    = MODE_W_DEF,
    parameter int DUR_W     = DUR_W_DEF,
    parameter int NUM_STEPS = NUM_STEPS_DEF
) (
    input  logic                Clk,
    input  logic                nReset,
    counter_sequencer_if.slave  bus
);
    localparam int SW    = $clog2(NUM_STEPS);
    localparam int NUM_W = SW + 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [SW-1:0]     r_step;
    logic [NUM_W-1:0]  r_num;
    logic [DUR_W-1:0]  r_rem;
    logic [MODE_W-1:0] r_mode;

    logic [MODE_W-1:0] w_rd_mode;
    logic [DUR_W-1:0]  w_rd_dur;
    logic              w_start_ok;
    logic              w_last;
    logic              w_loop;
    logic              w_dur_zero;
    logic              w_rem_one;
    logic [SW-1:0]     w_next_step;
    logic [NUM_W-1:0]  w_num_clamped;

    ctrseq_step_table #(
        .MODE_W    (MODE_W),
        .DUR_W     (DUR_W),
        .NUM_STEPS (NUM_STEPS)
    ) u_table (
        .Clk     (Clk),
        .nReset  (nReset),
        .i_we    (bus.Cfg_We && (r_state == IDLE)),
        .i_waddr (bus.Cfg_Addr),
        .i_mode  (bus.Cfg_Mode),
        .i_dur   (bus.Cfg_Dur),
        .i_raddr (r_step),
        .o_mode  (w_rd_mode),
        .o_dur   (w_rd_dur)
    );

    assign w_start_ok    = bus.Start && !bus.Abort && (bus.Cfg_Num != '0);
    assign w_num_clamped = (bus.Cfg_Num > NUM_W'(NUM_STEPS)) ? NUM_W'(NUM_STEPS) : bus.Cfg_Num;
    assign w_last        = ({1'b0, r_step} == (r_num - 1'b1));
    assign w_dur_zero    = (w_rd_dur == '0);
    assign w_rem_one     = (r_rem == DUR_W'(1));
    // After the last step either wrap to step 0 (looping) or hold for FIN.
    assign w_next_step   = w_last ? (w_loop ? '0 : r_step) : (r_step + 1'b1);

`ifdef CTRSEQ_LOOP_EN
    logic r_loop;

    // Loop request is latched together with an accepted Start.
    always_ff @(posedge Clk) begin
        if (!nReset)
            r_loop <= 1'b0;
        else if ((r_state == IDLE) && w_start_ok)
            r_loop <= bus.Loop;
    end

    assign w_loop = r_loop;
`else
    assign w_loop = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (!nReset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic; Abort overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        if (bus.Abort) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_start_ok) w_state_next = LOAD;
                LOAD: begin
                    if (w_dur_zero)
                        w_state_next = (w_last && !w_loop) ? FIN : LOAD;
                    else
                        w_state_next = RUN;
                end
                RUN: begin
                    if (w_rem_one)
                        w_state_next = (w_last && !w_loop) ? FIN : LOAD;
                end
                FIN:     w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Step index, step count and remaining-cycle counter.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            r_step <= '0;
            r_num  <= '0;
            r_rem  <= '0;
        end else if (bus.Abort) begin
            r_step <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_step <= '0;
                        r_num  <= w_num_clamped;
                    end
                end
                LOAD: begin
                    r_rem <= w_rd_dur;
                    if (w_dur_zero)
                        r_step <= w_next_step;
                end
                RUN: begin
                    r_rem <= r_rem - 1'b1;
                    if (w_rem_one)
                        r_step <= w_next_step;
                end
                default: r_step <= '0;
            endcase
        end
    end

    // Mode is captured in LOAD (even on Abort) so it persists afterwards.
    always_ff @(posedge Clk) begin
        if (!nReset)
            r_mode <= '0;
        else if (r_state == LOAD)
            r_mode <= w_rd_mode;
    end

    // Outputs decoded from the state register and registered datapath.
    always_comb begin
        bus.Ctr_Enable = (r_state == RUN);
        bus.Ctr_nClear = (r_state != LOAD);
        bus.Busy       = (r_state != IDLE);
        bus.Done       = (r_state == FIN);
        bus.Step       = r_step;
        bus.Ctr_Mode   = (r_state == LOAD) ? w_rd_mode : r_mode;
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: table-driven cycle vectors plus
// hand-written multi-cycle sequences (skip, clamp, abort, reset, loop).
module tb_counter_sequencer;

    logic clk;
    logic n_reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    counter_sequencer_if #(.MODE_W(4), .DUR_W(8), .NUM_STEPS(4)) bus_if ();

    counter_sequencer #(.MODE_W(4), .DUR_W(8), .NUM_STEPS(4)) dut (
        .Clk    (clk),
        .nReset (n_reset),
        .bus    (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       abort;
        logic       we;
        logic [1:0] addr;
        logic [3:0] mode;
        logic [7:0] dur;
        logic [2:0] num;
        logic       en;
        logic       ncl;
        logic [3:0] cmode;
        logic       busy;
        logic       done;
        logic [1:0] step;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mkv(input logic st, input logic ab, input logic we,
                                 input logic [1:0] ad, input logic [3:0] md,
                                 input logic [7:0] du, input logic [2:0] nm,
                                 input logic en, input logic ncl, input logic [3:0] cm,
                                 input logic bs, input logic dn, input logic [1:0] sp);
        vec_t v;
        v.start = st; v.abort = ab; v.we = we; v.addr = ad; v.mode = md; v.dur = du;
        v.num = nm; v.en = en; v.ncl = ncl; v.cmode = cm; v.busy = bs; v.done = dn;
        v.step = sp;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.Start    = 1'b0;
        bus_if.Abort    = 1'b0;
        bus_if.Cfg_We   = 1'b0;
        bus_if.Cfg_Addr = '0;
        bus_if.Cfg_Mode = '0;
        bus_if.Cfg_Dur  = '0;
        bus_if.Cfg_Num  = '0;
`ifdef CTRSEQ_LOOP_EN
        bus_if.Loop     = 1'b0;
`endif
    endtask

    task automatic wr(input int addr, input int mode, input int dur);
        bus_if.Cfg_We   = 1'b1;
        bus_if.Cfg_Addr = 2'(addr);
        bus_if.Cfg_Mode = 4'(mode);
        bus_if.Cfg_Dur  = 8'(dur);
        tick();
        bus_if.Cfg_We   = 1'b0;
    endtask

    // Start a sequence and observe it until Busy drops (cycle 1 = first LOAD).
    task automatic run_seq(input int num, input int max_cyc, output int done_at,
                           output int n_done, output int n_en, output int n_load,
                           output int end_cyc, output int first_mode);
        bus_if.Start   = 1'b1;
        bus_if.Cfg_Num = 3'(num);
        tick();
        bus_if.Start   = 1'b0;
        done_at = -1; n_done = 0; n_en = 0; n_load = 0; end_cyc = -1;
        first_mode = int'(bus_if.Ctr_Mode);
        for (int c = 1; c <= max_cyc; c++) begin
            if (!bus_if.Busy) begin
                end_cyc = c;
                break;
            end
            if (bus_if.Done) begin n_done++; done_at = c; end
            if (bus_if.Ctr_Enable) n_en++;
            if (!bus_if.Ctr_nClear) n_load++;
            tick();
        end
    endtask

    function automatic int pack_out();
        return int'({bus_if.Ctr_Enable, bus_if.Ctr_nClear, bus_if.Ctr_Mode,
                     bus_if.Busy, bus_if.Done, bus_if.Step});
    endfunction

    initial begin
        int done_at, n_done, n_en, n_load, end_cyc, first_mode, cnt;

        idle_inputs();
        n_reset = 1'b0;
        tick();
        tick();
        check("rst_enable", int'(bus_if.Ctr_Enable), 0);
        check("rst_nclear", int'(bus_if.Ctr_nClear), 1);
        check("rst_mode",   int'(bus_if.Ctr_Mode), 0);
        check("rst_busy",   int'(bus_if.Busy), 0);
        check("rst_done",   int'(bus_if.Done), 0);
        check("rst_step",   int'(bus_if.Step), 0);
        n_reset = 1'b1;
        tick();

        // Start with Cfg_Num = 0 is ignored.
        bus_if.Start = 1'b1;
        bus_if.Cfg_Num = 3'd0;
        tick();
        bus_if.Start = 1'b0;
        check("num0_busy", int'(bus_if.Busy), 0);

        // Cycle-by-cycle vectors; outputs checked just after the edge.
        wr(0, 9, 3);
        wr(1, 2, 2);
        //             st ab we ad md du nm  en ncl cm b d sp
        vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 2, 0, 0, 9, 1, 0, 0)); // LOAD step 0
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 1, 0, 0)); // RUN
        vecs.push_back(mkv(0, 0, 1, 0, 7, 3, 0, 1, 1, 9, 1, 0, 0)); // RUN, write ignored
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 1, 0, 0)); // RUN
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1)); // LOAD step 1
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 1, 0, 1)); // RUN
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 1, 0, 1)); // RUN
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 1, 1)); // FIN
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0)); // IDLE
        vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 2, 0, 0, 9, 1, 0, 0)); // rerun: mode 9 kept
        vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0)); // abort in LOAD
        vecs.push_back(mkv(1, 1, 0, 0, 0, 0, 2, 0, 1, 9, 0, 0, 0)); // start+abort: stay IDLE
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0)); // IDLE
        vecs.push_back(mkv(1, 0, 1, 0, 6, 1, 1, 0, 0, 6, 1, 0, 0)); // write+start: visible
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 1, 0, 0)); // RUN
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1, 1, 0)); // FIN
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0)); // IDLE
        for (int i = 0; i < vecs.size(); i++) begin
            int exp_v;
            bus_if.Start    = vecs[i].start;
            bus_if.Abort    = vecs[i].abort;
            bus_if.Cfg_We   = vecs[i].we;
            bus_if.Cfg_Addr = vecs[i].addr;
            bus_if.Cfg_Mode = vecs[i].mode;
            bus_if.Cfg_Dur  = vecs[i].dur;
            bus_if.Cfg_Num  = vecs[i].num;
            tick();
            exp_v = int'({vecs[i].en, vecs[i].ncl, vecs[i].cmode, vecs[i].busy,
                          vecs[i].done, vecs[i].step});
            n_tests++;
            if (pack_out() != exp_v) begin
                n_fail++;
                $display("FAIL vec%0d {en,ncl,mode,busy,done,step}: got %b_%b_%h_%b_%b_%0d expected %b_%b_%h_%b_%b_%0d",
                         i, bus_if.Ctr_Enable, bus_if.Ctr_nClear, bus_if.Ctr_Mode, bus_if.Busy,
                         bus_if.Done, bus_if.Step, vecs[i].en, vecs[i].ncl, vecs[i].cmode,
                         vecs[i].busy, vecs[i].done, vecs[i].step);
            end
        end
        idle_inputs();

        // Skipped step: (1+3) + (1+0) + (1+1) + FIN = 8 cycles.
        wr(0, 9, 3);
        wr(1, 1, 0);
        wr(2, 5, 1);
        run_seq(3, 30, done_at, n_done, n_en, n_load, end_cyc, first_mode);
        $display("[TB] skip: done_at=%0d dones=%0d en=%0d loads=%0d end=%0d", done_at, n_done, n_en, n_load, end_cyc);
        check("skip_done_at", done_at, 8);
        check("skip_n_done",  n_done, 1);
        check("skip_n_en",    n_en, 4);
        check("skip_n_load",  n_load, 3);
        check("skip_end",     end_cyc, 9);

        // Cfg_Num above NUM_STEPS clamps to 4 steps of duration 1.
        wr(0, 1, 1);
        wr(1, 2, 1);
        wr(2, 3, 1);
        wr(3, 4, 1);
        run_seq(7, 30, done_at, n_done, n_en, n_load, end_cyc, first_mode);
        $display("[TB] clamp: done_at=%0d en=%0d loads=%0d end=%0d", done_at, n_en, n_load, end_cyc);
        check("clamp_done_at", done_at, 9);
        check("clamp_n_en",    n_en, 4);
        check("clamp_n_load",  n_load, 4);
        check("clamp_mode0",   first_mode, 1);

        // Abort at the third Enable cycle of a long step.
        wr(0, 8, 200);
        bus_if.Start = 1'b1;
        bus_if.Cfg_Num = 3'd1;
        tick();
        bus_if.Start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10 && cnt < 3; i++) begin
            tick();
            if (bus_if.Ctr_Enable) cnt++;
        end
        check("abort_reach_run3", cnt, 3);
        bus_if.Abort = 1'b1;
        tick();
        bus_if.Abort = 1'b0;
        $display("[TB] abort: busy=%0d en=%0d mode=%0d", bus_if.Busy, bus_if.Ctr_Enable, bus_if.Ctr_Mode);
        check("abort_busy", int'(bus_if.Busy), 0);
        check("abort_en",   int'(bus_if.Ctr_Enable), 0);
        check("abort_mode", int'(bus_if.Ctr_Mode), 8);
        n_done = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus_if.Done) n_done++;
            tick();
        end
        check("abort_no_done", n_done, 0);
        wr(0, 4, 1);
        run_seq(1, 20, done_at, n_done, n_en, n_load, end_cyc, first_mode);
        $display("[TB] post-abort write: mode=%0d done_at=%0d en=%0d", first_mode, done_at, n_en);
        check("postabort_mode", first_mode, 4);
        check("postabort_done", done_at, 3);
        check("postabort_en",   n_en, 1);

        // Reset mid-sequence, then confirm the table was cleared.
        wr(0, 6, 5);
        wr(1, 7, 5);
        bus_if.Start = 1'b1;
        bus_if.Cfg_Num = 3'd2;
        tick();
        bus_if.Start = 1'b0;
        tick();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        check("midrst_busy", int'(bus_if.Busy), 0);
        check("midrst_en",   int'(bus_if.Ctr_Enable), 0);
        check("midrst_mode", int'(bus_if.Ctr_Mode), 0);
        run_seq(2, 20, done_at, n_done, n_en, n_load, end_cyc, first_mode);
        $display("[TB] cleared table: done_at=%0d en=%0d loads=%0d", done_at, n_en, n_load);
        check("clr_done_at", done_at, 3);
        check("clr_n_en",    n_en, 0);
        check("clr_n_load",  n_load, 2);
        check("clr_mode",    first_mode, 0);

`ifdef CTRSEQ_LOOP_EN
        // Looping single step: LOAD, RUN, RUN repeated, no Done.
        wr(0, 3, 2);
        bus_if.Loop = 1'b1;
        bus_if.Start = 1'b1;
        bus_if.Cfg_Num = 3'd1;
        tick();
        bus_if.Start = 1'b0;
        bus_if.Loop = 1'b0;
        n_done = 0;
        cnt = 0;
        for (int c = 0; c < 9; c++) begin
            if (bus_if.Done) n_done++;
            if ((bus_if.Ctr_nClear == (c % 3 == 0)) || (bus_if.Ctr_Enable != (c % 3 != 0)) ||
                !bus_if.Busy)
                cnt++;
            tick();
        end
        check("loop_pattern_errs", cnt, 0);
        check("loop_no_done", n_done, 0);
        bus_if.Abort = 1'b1;
        tick();
        bus_if.Abort = 1'b0;
        check("loop_abort_busy", int'(bus_if.Busy), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
